alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle control FSM for the RISC datapath: register file, A/B/C pipeline registers, shifter, ALU (add/sub, AND, NOT-B) and status register.
- Accepts one 16-bit instruction per start/ready handshake.
- Decodes the instruction, then steps the datapath through read-A, read-B, execute and write-back.
- Drives the ALU mode strobes (addSubVals/andVals/notBVal/sub) and all load enables; reports completion with a done pulse.

Parameters:
- INSTR_W, 16, instruction width; field positions below assume 16.
- RSEL_W, 3, register-select width (8 general registers).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  instruction offered; accepted only when ready=1.
- instr  in  INSTR_W  instruction word, sampled on acceptance.
- ready  out  1  FSM idle in WAIT.
- done  out  1  one-cycle pulse on return to WAIT after a legal instruction.
- illegal  out  1  one-cycle pulse on return to WAIT after an undecodable instruction.
- rf_rsel  out  RSEL_W  register-file read select.
- rf_wsel  out  RSEL_W  register-file write select.
- rf_we  out  1  register-file write enable.
- vsel  out  1  write-back source: 1 = sign-extended imm8, 0 = C register.
- imm_sx  out  16  sign-extended instr[7:0].
- loada, loadb, loadc, loads  out  1 each  datapath register load enables.
- asel  out  1  1 = force ALU A operand to 0.
- shift  out  2  shifter control, instr[4:3].
- addSubVals, andVals, notBVal, sub  out  1 each  ALU mode strobes; at most one of addSubVals/andVals/notBVal high.

Behaviour:
- Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Decode table:
  - 110/10: MOV imm, Rn <= sx(imm8).
  - 110/00: MOV reg, Rd <= sh(Rm).
  - 101/00: ADD, Rd <= Rn + sh(Rm).
  - 101/01: CMP, status <= Rn - sh(Rm); no write.
  - 101/10: AND, Rd <= Rn & sh(Rm).
  - 101/11: MVN, Rd <= ~sh(Rm).
  - Any other opcode/op: illegal.
- Acceptance: start & ready at edge N. Instruction is latched into an internal register; state goes WAIT -> DECODE. start while not ready is ignored; the latched instruction is unchanged.
- States:
  - WAIT: ready=1.
  - DECODE: no loads.
  - WRITE_IMM: rf_wsel=Rn, vsel=1, rf_we=1.
  - GET_A: rf_rsel=Rn, loada=1.
  - GET_B: rf_rsel=Rm, loadb=1.
  - EXEC: loadc=1 (except CMP). loads=1 for ADD/CMP/AND/MVN and 0 for MOV reg. asel=1 for MOV reg/MVN.
  - WRITE_REG: rf_wsel=Rd, vsel=0, rf_we=1.
- Transitions from DECODE:
  - MOV imm: WRITE_IMM -> WAIT.
  - MOV reg: GET_B -> EXEC (addSubVals, sub=0) -> WRITE_REG -> WAIT.
  - ADD: GET_A -> GET_B -> EXEC (addSubVals, sub=0) -> WRITE_REG -> WAIT.
  - AND: GET_A -> GET_B -> EXEC (andVals) -> WRITE_REG -> WAIT.
  - CMP: GET_A -> GET_B -> EXEC (addSubVals, sub=1, loadc=0) -> WAIT.
  - MVN: GET_B -> EXEC (notBVal) -> WRITE_REG -> WAIT.
  - Illegal: WAIT directly; no load or write ever asserted.
- Latency, acceptance edge to done-high cycle:
  - MOV imm: 3.
  - MVN, MOV reg: 5.
  - CMP: 5.
  - ADD, AND: 6.
  - Illegal: 2.
- Output timing: all control outputs are Moore, decoded from state and the latched instruction. ALU strobes are 0 outside EXEC. done/illegal are registered and high only in the first WAIT cycle after completion.
- Back-to-back: start may be accepted in the same cycle done is high. No idle cycle is required.
- Reset (any time, including mid-instruction):
  - State = WAIT, instruction register = 0.
  - ready=1; every other output 0.
  - A write-back in progress is aborted and rf_we deasserts asynchronously.
- rf_rsel/rf_wsel are 0 in states that do not use them.

Decomposition:
- Shared package alu_ctrl_pkg:
  - Opcode/op localparams (OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD..OP_MVN).
  - State enum (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG).
  - Instruction field-slice constants.
- One sub-module, instr_field_decode: combinational extraction of Rn/Rd/Rm/sh/imm_sx plus a legality flag. The FSM stays in alu_op_sequencer.

Test Plan:
- rst_n low mid-ADD in EXEC -> same cycle: rf_we=0, ALU strobes 0, ready=1. After release, MOV imm 16'hD205 writes R2 <= 5 with done 3 cycles after acceptance.
- instr 16'hD0FF (MOV R0, #-1) -> WRITE_IMM with rf_wsel=0, imm_sx=16'hFFFF, vsel=1; done at cycle 3.
- ADD R3=R1+R2 (16'hA162) -> rf_rsel sequence 1,2; EXEC with addSubVals=1, sub=0, loads=1; WRITE_REG rf_wsel=3; done at cycle 6.
- CMP R1,R2 (16'hA902) -> EXEC with sub=1, loads=1, loadc=0; rf_we never asserted; done at cycle 5.
- MVN R4,R7 (16'hB887) -> GET_A skipped; EXEC with notBVal=1, asel=1; WRITE_REG rf_wsel=4.
- Illegal 16'hE000, then start held high during an ADD -> illegal pulse at cycle 2 with no loads. Second start is ignored while busy and the latched instruction is unchanged.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU operation sequencer: opcode/op values,
// instruction field positions, FSM states and decoded instruction classes.
package alu_ctrl_pkg;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // Low bit of each field in a 16-bit instruction word.
    localparam int OPC_LSB = 13;
    localparam int OP_LSB  = 11;
    localparam int RN_LSB  = 8;
    localparam int RD_LSB  = 5;
    localparam int SH_LSB  = 3;
    localparam int RM_LSB  = 0;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_ILLEGAL = 3'd0,
        K_MOV_IMM = 3'd1,
        K_MOV_REG = 3'd2,
        K_ADD     = 3'd3,
        K_CMP     = 3'd4,
        K_AND     = 3'd5,
        K_MVN     = 3'd6
    } kind_t;

    function automatic logic [15:0] sign_ext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake and datapath control bundle between an instruction
// source (master) and the ALU operation sequencer (slave).
interface alu_op_sequencer_if #(
    parameter int INSTR_W = 16,
    parameter int RSEL_W  = 3
);
    logic               start;
    logic [INSTR_W-1:0] instr;
    logic               ready;
    logic               done;
    logic               illegal;
    logic [RSEL_W-1:0]  rf_rsel;
    logic [RSEL_W-1:0]  rf_wsel;
    logic               rf_we;
    logic               vsel;
    logic [15:0]        imm_sx;
    logic               loada;
    logic               loadb;
    logic               loadc;
    logic               loads;
    logic               asel;
    logic [1:0]         shift;
    logic               addSubVals;
    logic               andVals;
    logic               notBVal;
    logic               sub;

    modport master (
        output start, instr,
        input  ready, done, illegal, rf_rsel, rf_wsel, rf_we, vsel, imm_sx,
               loada, loadb, loadc, loads, asel, shift,
               addSubVals, andVals, notBVal, sub
    );

    modport slave (
        input  start, instr,
        output ready, done, illegal, rf_rsel, rf_wsel, rf_we, vsel, imm_sx,
               loada, loadb, loadc, loads, asel, shift,
               addSubVals, andVals, notBVal, sub
    );

endinterface

// File: rtl/instr_field_decode.sv
// Combinational slicing of an instruction word into register selects, shift,
// sign-extended immediate and instruction class with a legality flag.
module instr_field_decode
    import alu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int RSEL_W  = 3
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [RSEL_W-1:0]  rn,
    output logic [RSEL_W-1:0]  rd,
    output logic [RSEL_W-1:0]  rm,
    output logic [1:0]         sh,
    output logic [15:0]        imm_sx,
    output kind_t              kind,
    output logic               legal
);

    logic [2:0] opc_s;
    logic [1:0] op_s;

    assign opc_s  = instr[OPC_LSB +: 3];
    assign op_s   = instr[OP_LSB +: 2];
    assign rn     = instr[RN_LSB +: RSEL_W];
    assign rd     = instr[RD_LSB +: RSEL_W];
    assign rm     = instr[RM_LSB +: RSEL_W];
    assign sh     = instr[SH_LSB +: 2];
    assign imm_sx = sign_ext8(instr[IMM_LSB +: 8]);

    // Opcode/op pair to instruction class; anything outside the table is illegal.
    always_comb begin
        kind = K_ILLEGAL;
        case ({opc_s, op_s})
            {OPC_MOV, OP_MOV_IMM}: kind = K_MOV_IMM;
            {OPC_MOV, OP_MOV_REG}: kind = K_MOV_REG;
            {OPC_ALU, OP_ADD}:     kind = K_ADD;
            {OPC_ALU, OP_CMP}:     kind = K_CMP;
            {OPC_ALU, OP_AND}:     kind = K_AND;
            {OPC_ALU, OP_MVN}:     kind = K_MVN;
            default:               kind = K_ILLEGAL;
        endcase
    end

    assign legal = (kind != K_ILLEGAL);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM that accepts one instruction per handshake and steps
// the register file / ALU datapath through read, execute and write-back.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int RSEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);

    typedef struct packed {
        logic              ready;
        logic              done;
        logic              illegal;
        logic [RSEL_W-1:0] rf_rsel;
        logic [RSEL_W-1:0] rf_wsel;
        logic              rf_we;
        logic              vsel;
        logic [15:0]       imm_sx;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              asel;
        logic [1:0]        shift;
        logic              add_sub_vals;
        logic              and_vals;
        logic              not_b_val;
        logic              sub;
    } ctrl_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [INSTR_W-1:0] instr_r;
    logic [INSTR_W-1:0] instr_nxt_s;
    ctrl_t              ctrl_r;
    ctrl_t              ctrl_nxt_s;

    logic [RSEL_W-1:0]  rn_s;
    logic [RSEL_W-1:0]  rd_s;
    logic [RSEL_W-1:0]  rm_s;
    logic [1:0]         sh_s;
    logic [15:0]        imm_sx_s;
    kind_t              kind_s;
    logic               legal_s;

    // Decoding the next instruction lets every output be registered yet
    // still line up with the state it belongs to.
    instr_field_decode #(
        .INSTR_W (INSTR_W),
        .RSEL_W  (RSEL_W)
    ) u_decode (
        .instr  (instr_nxt_s),
        .rn     (rn_s),
        .rd     (rd_s),
        .rm     (rm_s),
        .sh     (sh_s),
        .imm_sx (imm_sx_s),
        .kind   (kind_s),
        .legal  (legal_s)
    );

    // Next state and instruction latch; starts are only honoured in WAIT.
    always_comb begin
        state_nxt_s = state_r;
        instr_nxt_s = instr_r;
        case (state_r)
            ST_WAIT: begin
                if (bus.start) begin
                    state_nxt_s = ST_DECODE;
                    instr_nxt_s = bus.instr;
                end else begin
                    state_nxt_s = ST_WAIT;
                    instr_nxt_s = instr_r;
                end
            end
            ST_DECODE: begin
                if (!legal_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    case (kind_s)
                        K_MOV_IMM:              state_nxt_s = ST_WRITE_IMM;
                        K_MOV_REG, K_MVN:       state_nxt_s = ST_GET_B;
                        K_ADD, K_CMP, K_AND:    state_nxt_s = ST_GET_A;
                        default:                state_nxt_s = ST_WAIT;
                    endcase
                end
            end
            ST_WRITE_IMM: state_nxt_s = ST_WAIT;
            ST_GET_A:     state_nxt_s = ST_GET_B;
            ST_GET_B:     state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                if (kind_s == K_CMP) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: state_nxt_s = ST_WAIT;
            default:      state_nxt_s = ST_WAIT;
        endcase
    end

    // Control word for the state being entered; done/illegal mark the exit path.
    always_comb begin
        ctrl_nxt_s        = '0;
        ctrl_nxt_s.imm_sx = imm_sx_s;
        ctrl_nxt_s.shift  = sh_s;
        case (state_nxt_s)
            ST_WAIT: begin
                ctrl_nxt_s.ready   = 1'b1;
                ctrl_nxt_s.done    = (state_r == ST_WRITE_IMM) || (state_r == ST_EXEC) ||
                                     (state_r == ST_WRITE_REG);
                ctrl_nxt_s.illegal = (state_r == ST_DECODE);
            end
            ST_DECODE: begin
                ctrl_nxt_s.ready = 1'b0;
            end
            ST_WRITE_IMM: begin
                ctrl_nxt_s.rf_wsel = rn_s;
                ctrl_nxt_s.vsel    = 1'b1;
                ctrl_nxt_s.rf_we   = 1'b1;
            end
            ST_GET_A: begin
                ctrl_nxt_s.rf_rsel = rn_s;
                ctrl_nxt_s.loada   = 1'b1;
            end
            ST_GET_B: begin
                ctrl_nxt_s.rf_rsel = rm_s;
                ctrl_nxt_s.loadb   = 1'b1;
            end
            ST_EXEC: begin
                ctrl_nxt_s.loadc        = (kind_s != K_CMP);
                ctrl_nxt_s.loads        = (kind_s != K_MOV_REG);
                ctrl_nxt_s.asel         = (kind_s == K_MOV_REG) || (kind_s == K_MVN);
                ctrl_nxt_s.add_sub_vals = (kind_s == K_ADD) || (kind_s == K_CMP) ||
                                          (kind_s == K_MOV_REG);
                ctrl_nxt_s.and_vals     = (kind_s == K_AND);
                ctrl_nxt_s.not_b_val    = (kind_s == K_MVN);
                ctrl_nxt_s.sub          = (kind_s == K_CMP);
            end
            ST_WRITE_REG: begin
                ctrl_nxt_s.rf_wsel = rd_s;
                ctrl_nxt_s.vsel    = 1'b0;
                ctrl_nxt_s.rf_we   = 1'b1;
            end
            default: begin
                ctrl_nxt_s.ready = 1'b0;
            end
        endcase
    end

    // FSM state, instruction register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_WAIT;
            instr_r      <= '0;
            ctrl_r       <= '0;
            ctrl_r.ready <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            instr_r <= instr_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    assign bus.ready      = ctrl_r.ready;
    assign bus.done       = ctrl_r.done;
    assign bus.illegal    = ctrl_r.illegal;
    assign bus.rf_rsel    = ctrl_r.rf_rsel;
    assign bus.rf_wsel    = ctrl_r.rf_wsel;
    assign bus.rf_we      = ctrl_r.rf_we;
    assign bus.vsel       = ctrl_r.vsel;
    assign bus.imm_sx     = ctrl_r.imm_sx;
    assign bus.loada      = ctrl_r.loada;
    assign bus.loadb      = ctrl_r.loadb;
    assign bus.loadc      = ctrl_r.loadc;
    assign bus.loads      = ctrl_r.loads;
    assign bus.asel       = ctrl_r.asel;
    assign bus.shift      = ctrl_r.shift;
    assign bus.addSubVals = ctrl_r.add_sub_vals;
    assign bus.andVals    = ctrl_r.and_vals;
    assign bus.notBVal    = ctrl_r.not_b_val;
    assign bus.sub        = ctrl_r.sub;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: each accepted instruction queues its hand-computed
// per-cycle control trace; a monitor compares the DUT every falling edge.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          idx;
        logic [19:0] ctl;
        logic [15:0] imm;
        logic [1:0]  sh;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] pend_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // ctl layout: ready done illegal | rsel | wsel | we vsel | la lb lc ls | asel | add and notb sub
    localparam logic [19:0] DEC  = 20'b000_000_000_00_0000_0_0000;
    localparam logic [19:0] FIN  = 20'b110_000_000_00_0000_0_0000;
    localparam logic [19:0] BAD  = 20'b101_000_000_00_0000_0_0000;
    localparam logic [19:0] IDLE = 20'b100_000_000_00_0000_0_0000;

    function automatic logic [19:0] observe();
        return {bus.ready, bus.done, bus.illegal, bus.rf_rsel, bus.rf_wsel,
                bus.rf_we, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.addSubVals, bus.andVals, bus.notBVal, bus.sub};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic tp(input logic [19:0] c);
        pend_q.push_back(c);
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (bus.ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: ready not seen within 64 cycles", nm);
        end
    endtask

    // Offer an instruction at the first ready falling edge; queue its trace on acceptance.
    task automatic issue(input string nm, input logic [15:0] iw,
                         input logic [15:0] imm, input logic [1:0] sh);
        exp_t e;
        @(negedge clk);
        wait_ready(nm);
        bus.start = 1'b1;
        bus.instr = iw;
        @(posedge clk);
        for (int i = 0; i < pend_q.size(); i++) begin
            e.nm  = nm;
            e.idx = i;
            e.ctl = pend_q[i];
            e.imm = imm;
            e.sh  = sh;
            exp_q.push_back(e);
        end
        pend_q.delete();
        #1 bus.start = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && exp_q.size() > 0) begin
                n_chk++;
                if (observe() !== exp_q[0].ctl || bus.imm_sx !== exp_q[0].imm ||
                    bus.shift !== exp_q[0].sh) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: ctl=%b imm=%h sh=%b, expected ctl=%b imm=%h sh=%b",
                             exp_q[0].nm, exp_q[0].idx, observe(), bus.imm_sx, bus.shift,
                             exp_q[0].ctl, exp_q[0].imm, exp_q[0].sh);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin : stimulus
        int k;
        bus.start = 1'b0;
        bus.instr = 16'h0000;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'(observe()), 32'(IDLE));
        chk("reset_imm", 32'(bus.imm_sx), 32'h0);
        chk("reset_shift", 32'(bus.shift), 32'h0);
        #2 rst_n = 1'b1;

        // MOV R0, #-1
        tp(DEC); tp(20'b000_000_000_11_0000_0_0000); tp(FIN);
        issue("movi_r0", 16'hD0FF, 16'hFFFF, 2'b11);
        // ADD R3 = R1 + R2, back to back
        tp(DEC); tp(20'b000_001_000_00_1000_0_0000); tp(20'b000_010_000_00_0100_0_0000);
        tp(20'b000_000_000_00_0011_0_1000); tp(20'b000_000_011_10_0000_0_0000); tp(FIN);
        issue("add_r3", 16'hA162, 16'h0062, 2'b00);
        // CMP R1, R2
        tp(DEC); tp(20'b000_001_000_00_1000_0_0000); tp(20'b000_010_000_00_0100_0_0000);
        tp(20'b000_000_000_00_0001_0_1001); tp(FIN);
        issue("cmp_r1r2", 16'hA902, 16'h0002, 2'b00);
        // MVN R4, R7
        tp(DEC); tp(20'b000_111_000_00_0100_0_0000); tp(20'b000_000_000_00_0011_1_0010);
        tp(20'b000_000_100_10_0000_0_0000); tp(FIN);
        issue("mvn_r4", 16'hB887, 16'hFF87, 2'b00);
        // MOV R2, R3 with shift field 01
        tp(DEC); tp(20'b000_011_000_00_0100_0_0000); tp(20'b000_000_000_00_0010_1_1000);
        tp(20'b000_000_010_10_0000_0_0000); tp(FIN);
        issue("movr_r2", 16'hC04B, 16'h004B, 2'b01);
        // AND R7 = R4 & R1
        tp(DEC); tp(20'b000_100_000_00_1000_0_0000); tp(20'b000_001_000_00_0100_0_0000);
        tp(20'b000_000_000_00_0011_0_0100); tp(20'b000_000_111_10_0000_0_0000); tp(FIN);
        issue("and_r7", 16'hB4E9, 16'hFFE9, 2'b01);
        // MOV opcode with an unused op
        tp(DEC); tp(BAD);
        issue("ill_c800", 16'hC800, 16'h0000, 2'b00);

        // Illegal opcode, then ADD with start held high while busy
        tp(DEC); tp(BAD);
        issue("ill_e000", 16'hE000, 16'h0000, 2'b00);
        tp(DEC); tp(20'b000_001_000_00_1000_0_0000); tp(20'b000_010_000_00_0100_0_0000);
        tp(20'b000_000_000_00_0011_0_1000); tp(20'b000_000_011_10_0000_0_0000); tp(FIN);
        issue("add_busy", 16'hA162, 16'h0062, 2'b00);
        bus.start = 1'b1;
        bus.instr = 16'hD0FF;
        @(negedge clk);
        wait_ready("add_busy_hold");
        bus.start = 1'b0;

        // Reset while an ADD sits in EXEC
        tp(DEC); tp(20'b000_001_000_00_1000_0_0000); tp(20'b000_010_000_00_0100_0_0000);
        issue("add_rst", 16'hA162, 16'h0062, 2'b00);
        repeat (3) @(posedge clk);
        #2;
        chk("exec_addsub_before_rst", 32'(bus.addSubVals), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(bus.rf_we), 32'h0);
        chk("rst_mid_strobes", 32'({bus.addSubVals, bus.andVals, bus.notBVal, bus.sub}), 32'h0);
        chk("rst_mid_ready", 32'(bus.ready), 32'h1);
        chk("rst_mid_ctl", 32'(observe()), 32'(IDLE));
        chk("rst_mid_imm", 32'(bus.imm_sx), 32'h0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // MOV R2, #5 after reset
        tp(DEC); tp(20'b000_000_010_11_0000_0_0000); tp(FIN);
        issue("movi_r2", 16'hD205, 16'h0005, 2'b00);

        k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected cycles never observed", exp_q.size());
        end
        repeat (2) @(negedge clk);
        chk("idle_ctl", 32'(observe()), 32'(IDLE));
        chk("idle_imm", 32'(bus.imm_sx), 32'h0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
